// File: rtl/rv_pkg.sv
// Shared encodings for the load/store write-back path: access sizes, funct3
// field positions and the controller state type.
package rv_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  localparam int F3_UNSIGNED = 2;
  localparam int F3_SIZE_HI  = 1;
  localparam int F3_SIZE_LO  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data shift and strobes, load
// extraction with sign/zero extension, and the natural-alignment test.
module lsu_align
  import rv_pkg::*;
#(
  parameter  int XLEN   = 64,
  localparam int STRB_W = XLEN / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  off,
  input  mem_size_e         size,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   st_data,
  input  logic [XLEN-1:0]   ld_raw,
  output logic [XLEN-1:0]   st_wdata,
  output logic [STRB_W-1:0] st_strb,
  output logic [XLEN-1:0]   ld_data,
  output logic              misaligned
);

  logic [STRB_W-1:0] strb_base;
  logic [XLEN-1:0]   shifted;
  logic              fill;
  int                nbits;

  assign st_wdata = st_data << {off, 3'b000};
  assign st_strb  = strb_base << off;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    strb_base  = '1;
    misaligned = 1'b0;
    case (size)
      MEM_B: begin
        strb_base  = STRB_W'(1);
        misaligned = 1'b0;
      end
      MEM_H: begin
        strb_base  = STRB_W'(3);
        misaligned = off[0];
      end
      MEM_W: begin
        strb_base  = STRB_W'(15);
        misaligned = |off[1:0];
      end
      MEM_D: begin
        strb_base  = '1;
        // Doubleword accesses do not exist on a 32-bit datapath.
        misaligned = (XLEN != 64) || (|off);
      end
    endcase
  end

  always_comb begin
    shifted = ld_raw >> {off, 3'b000};
    nbits   = XLEN;
    fill    = 1'b0;
    ld_data = shifted;
    case (size)
      MEM_B: begin nbits = 8;    fill = shifted[7];      end
      MEM_H: begin nbits = 16;   fill = shifted[15];     end
      MEM_W: begin nbits = 32;   fill = shifted[31];     end
      MEM_D: begin nbits = XLEN; fill = shifted[XLEN-1]; end
    endcase
    if (is_unsigned) fill = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      ld_data[i] = (i < nbits) ? shifted[i] : fill;
    end
  end

endmodule

// File: rtl/lsu_wb_ctrl.sv
// Load/store and write-back controller: accepts one instruction at a time,
// runs the memory handshake if needed, and presents one registered write-back beat.
module lsu_wb_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_load,
  input  logic                in_is_store,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_alu_res,
  input  logic [XLEN-1:0]     in_rs2,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                in_wb_en,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_rdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RD_W-1:0]     wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_en,
  output logic                misalign
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  lsu_state_e        state;
  logic [OFF_W-1:0]  off_q;
  mem_size_e         size_q;
  logic              uns_q;
  logic              is_load_q;
  logic              wb_en_q;
  logic [RD_W-1:0]   rd_q;

  logic [ADDR_W-1:0] in_addr;
  logic [XLEN-1:0]   in_addr_ext;
  mem_size_e         in_size;
  logic              in_mem;
  logic              in_rd_nz;

  mem_size_e         al_size;
  logic [OFF_W-1:0]  al_off;
  logic              al_uns;
  logic [XLEN-1:0]   al_wdata;
  logic [STRB_W-1:0] al_strb;
  logic [XLEN-1:0]   al_ld_data;
  logic              al_misaligned;

  assign in_addr     = in_alu_res[ADDR_W-1:0];
  assign in_addr_ext = XLEN'(in_addr);
  assign in_size     = mem_size_e'(in_funct3[F3_SIZE_HI:F3_SIZE_LO]);
  assign in_mem      = in_is_load | in_is_store;
  assign in_rd_nz    = (in_rd != '0);

  // The aligner sees the live instruction while idle and the captured one afterwards.
  always_comb begin
    al_off  = off_q;
    al_size = size_q;
    al_uns  = uns_q;
    if (state == IDLE) begin
      al_off  = in_addr[OFF_W-1:0];
      al_size = in_size;
      al_uns  = in_funct3[F3_UNSIGNED];
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .off         (al_off),
    .size        (al_size),
    .is_unsigned (al_uns),
    .st_data     (in_rs2),
    .ld_raw      (mem_rsp_rdata),
    .st_wdata    (al_wdata),
    .st_strb     (al_strb),
    .ld_data     (al_ld_data),
    .misaligned  (al_misaligned)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; rst_n is only looked at on the clock edge.
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      off_q         <= '0;
      size_q        <= MEM_B;
      uns_q         <= 1'b0;
      is_load_q     <= 1'b0;
      wb_en_q       <= 1'b0;
      rd_q          <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_en         <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready  <= 1'b0;
            off_q     <= in_addr[OFF_W-1:0];
            size_q    <= in_size;
            uns_q     <= in_funct3[F3_UNSIGNED];
            is_load_q <= in_is_load;
            wb_en_q   <= in_wb_en & in_rd_nz;
            rd_q      <= in_rd;
            if (in_mem && !al_misaligned) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_we    <= in_is_store;
              mem_req_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_req_wdata <= in_is_store ? al_wdata : '0;
              mem_req_wstrb <= in_is_store ? al_strb : '0;
            end else begin
              // Misaligned accesses report the faulting address for mtval.
              state    <= WB;
              wb_valid <= 1'b1;
              wb_rd    <= in_rd;
              wb_data  <= in_mem ? in_addr_ext : in_alu_res;
              wb_en    <= !in_mem && in_wb_en && in_rd_nz;
              misalign <= in_mem;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state    <= WB;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= is_load_q ? al_ld_data : '0;
            wb_en    <= is_load_q & wb_en_q;
            misalign <= 1'b0;
          end
        end
        WB: begin
          if (wb_ready) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_en    <= 1'b0;
            misalign <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb_ctrl.sv
// Directed bench for lsu_wb_ctrl at XLEN=64: loads, stores, misalignment,
// backpressure and mid-transaction reset, each with hand-computed expectations.
module tb_lsu_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_res;
  logic [63:0] in_rs2;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_en;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_wb_ctrl #(.XLEN(64), .ADDR_W(64), .RD_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_alu_res    (in_alu_res),
    .in_rs2        (in_rs2),
    .in_rd         (in_rd),
    .in_wb_en      (in_wb_en),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_en         (wb_en),
    .misalign      (misalign)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] alu, input logic [63:0] rs2,
                       input logic [4:0] rd, input logic wen);
    in_is_load  = ld;
    in_is_store = st;
    in_funct3   = f3;
    in_alu_res  = alu;
    in_rs2      = rs2;
    in_rd       = rd;
    in_wb_en    = wen;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic wait_wb(input string tag);
    for (int i = 0; i < 20 && !wb_valid; i++) tick();
    check({tag, " wb_valid"}, wb_valid, 1'b1);
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_is_load    = 1'b0;
    in_is_store   = 1'b0;
    in_funct3     = 3'd0;
    in_alu_res    = '0;
    in_rs2        = '0;
    in_rd         = '0;
    in_wb_en      = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = '0;
    wb_ready      = 1'b1;
    tick();
    tick();
    check("rst in_ready", in_ready, 1'b1);
    check("rst mem_req_valid", mem_req_valid, 1'b0);
    check("rst wb_valid", wb_valid, 1'b0);
    check("rst wb_data", wb_data, 64'h0);
    check("rst mem_req_addr", mem_req_addr, 64'h0);
    rst_n = 1'b1;
    tick();
    check("post-rst in_ready", in_ready, 1'b1);

    // LD 0x1000 at minimum latency
    mem_rsp_rdata = 64'h8877665544332211;
    issue(1'b1, 1'b0, 3'b011, 64'h1000, 64'h0, 5'd5, 1'b1);
    check("ld req_valid", mem_req_valid, 1'b1);
    check("ld req_addr", mem_req_addr, 64'h1000);
    check("ld req_we", mem_req_we, 1'b0);
    check("ld in_ready", in_ready, 1'b0);
    tick();
    check("ld cyc2 wb_valid", wb_valid, 1'b0);
    tick();
    check("ld cyc3 wb_valid", wb_valid, 1'b1);
    check("ld wb_data", wb_data, 64'h8877665544332211);
    check("ld wb_en", wb_en, 1'b1);
    check("ld wb_rd", wb_rd, 5'd5);
    check("ld misalign", misalign, 1'b0);
    tick();
    check("ld handoff wb_valid", wb_valid, 1'b0);
    check("ld handoff in_ready", in_ready, 1'b1);

    // LB / LBU 0x1003
    mem_rsp_rdata = 64'h0000_0000_F000_0000;
    issue(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 5'd6, 1'b1);
    check("lb req_addr", mem_req_addr, 64'h1000);
    wait_wb("lb");
    check("lb wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FFF0);
    tick();
    issue(1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 5'd6, 1'b1);
    wait_wb("lbu");
    check("lbu wb_data", wb_data, 64'h0000_0000_0000_00F0);
    tick();

    // LW / LWU 0x1004, upper word
    mem_rsp_rdata = 64'h8000_0001_1234_5678;
    issue(1'b1, 1'b0, 3'b010, 64'h1004, 64'h0, 5'd9, 1'b1);
    wait_wb("lw");
    check("lw wb_data", wb_data, 64'hFFFF_FFFF_8000_0001);
    tick();
    issue(1'b1, 1'b0, 3'b110, 64'h1004, 64'h0, 5'd9, 1'b1);
    wait_wb("lwu");
    check("lwu wb_data", wb_data, 64'h0000_0000_8000_0001);
    tick();

    // SH 0x1006 with request and write-back backpressure
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    wb_ready      = 1'b0;
    issue(1'b0, 1'b1, 3'b001, 64'h1006, 64'h1234_0000_0000_ABCD, 5'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'b1;
      in_alu_res = 64'h2000 + 64'(i);
      check("sh req_valid", mem_req_valid, 1'b1);
      check("sh req_we", mem_req_we, 1'b1);
      check("sh req_addr", mem_req_addr, 64'h1000);
      check("sh req_wstrb", mem_req_wstrb, 8'hC0);
      check("sh req_wdata", mem_req_wdata, 64'hABCD_0000_0000_0000);
      check("sh req in_ready", in_ready, 1'b0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    check("sh wait req_valid", mem_req_valid, 1'b0);
    check("sh wait wb_valid", wb_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sh wb_valid", wb_valid, 1'b1);
      check("sh wb_en", wb_en, 1'b0);
      check("sh wb_rd", wb_rd, 5'd3);
      check("sh misalign", misalign, 1'b0);
      check("sh wb in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    check("sh handoff wb_valid", wb_valid, 1'b0);
    check("sh handoff in_ready", in_ready, 1'b1);
    mem_rsp_valid = 1'b1;

    // LW 0x1002 is misaligned: straight to write-back
    issue(1'b1, 1'b0, 3'b010, 64'h1002, 64'h0, 5'd4, 1'b1);
    check("mis req_valid", mem_req_valid, 1'b0);
    check("mis wb_valid", wb_valid, 1'b1);
    check("mis misalign", misalign, 1'b1);
    check("mis wb_data", wb_data, 64'h1002);
    check("mis wb_en", wb_en, 1'b0);
    tick();

    // Non-memory ops, including rd == 0
    issue(1'b0, 1'b0, 3'b000, 64'hDEAD_BEEF_0123_4567, 64'h0, 5'd7, 1'b1);
    check("alu wb_valid", wb_valid, 1'b1);
    check("alu wb_data", wb_data, 64'hDEAD_BEEF_0123_4567);
    check("alu wb_en", wb_en, 1'b1);
    check("alu wb_rd", wb_rd, 5'd7);
    check("alu misalign", misalign, 1'b0);
    tick();
    issue(1'b0, 1'b0, 3'b000, 64'h55, 64'h0, 5'd0, 1'b1);
    check("alu x0 wb_valid", wb_valid, 1'b1);
    check("alu x0 wb_en", wb_en, 1'b0);
    tick();

    // Reset while waiting for a response
    mem_rsp_valid = 1'b0;
    issue(1'b1, 1'b0, 3'b011, 64'h3000, 64'h0, 5'd8, 1'b1);
    tick();
    check("rstw in_ready before", in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    check("rstw in_ready", in_ready, 1'b1);
    check("rstw req_valid", mem_req_valid, 1'b0);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstw late rsp wb_valid", wb_valid, 1'b0);
      check("rstw late in_ready", in_ready, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
